// File: rtl/window_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// window_fetch_ctrl
//   Walks a WIN x WIN window across an IMG_W x IMG_H byte image in raster
//   order, stepping STRIDE pixels horizontally and vertically. For each window
//   it issues one read of the packed window word at the window's top-left byte
//   address, captures the returned word, and offers it downstream with a
//   valid/ready handshake.
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   begin a full-image scan (honoured only when idle)
//   abort      in   terminate a scan in progress at the next edge
//   busy       out  scan in progress
//   done       out  one-cycle pulse after the last window is accepted
//   ren        out  memory read enable (one cycle per window)
//   raddr      out  window top-left byte address
//   rdata      in   window word, registered by memory, valid the cycle after ren
//   win_valid  out  win_data holds an unconsumed window
//   win_ready  in   downstream accepts the window
//   win_data   out  captured window, row 0 pixel 0 in the MSBs
//   win_row    out  top row of the current window
//   win_col    out  left column of the current window
// -----------------------------------------------------------------------------
module window_fetch_ctrl #(
  parameter int IMG_W   = 640,
  parameter int IMG_H   = 480,
  parameter int WIN     = 7,
  parameter int STRIDE  = 1,
  parameter int A_WIDTH = 19,
  parameter int MASKLEN = 392
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic               ren,
  output logic [A_WIDTH-1:0] raddr,
  input  logic [MASKLEN-1:0] rdata,
  output logic               win_valid,
  input  logic               win_ready,
  output logic [MASKLEN-1:0] win_data,
  output logic [9:0]         win_row,
  output logic [9:0]         win_col
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPTURE,
    S_HOLD,
    S_FIN
  } state_t;

  // Largest legal top-left coordinates; 11 bits so the step never wraps.
  localparam logic [10:0]        COL_MAX   = 11'(IMG_W - WIN);
  localparam logic [10:0]        ROW_MAX   = 11'(IMG_H - WIN);
  localparam logic [10:0]        STEP      = 11'(STRIDE);
  // Constant address increment for one vertical step (parameter product only).
  localparam logic [A_WIDTH-1:0] ROW_PITCH = A_WIDTH'(IMG_W * STRIDE);

  state_t               r_state;
  state_t               w_state_next;
  logic [9:0]           r_row;
  logic [9:0]           r_col;
  logic [A_WIDTH-1:0]   r_row_base;
  logic [MASKLEN-1:0]   r_win_data;

  logic [10:0]          w_col_step;
  logic [10:0]          w_row_step;
  logic                 w_col_ok;
  logic                 w_row_ok;
  logic                 w_last;
  logic                 w_accept;
  logic                 w_launch;

  assign w_col_step = {1'b0, r_col} + STEP;
  assign w_row_step = {1'b0, r_row} + STEP;
  assign w_col_ok   = (w_col_step <= COL_MAX);
  assign w_row_ok   = (w_row_step <= ROW_MAX);
  // Last window: neither a horizontal nor a vertical step stays in the image.
  assign w_last     = !w_col_ok && !w_row_ok;
  // abort outranks both the downstream handshake and a start request.
  assign w_accept   = (r_state == S_HOLD) && win_ready && !abort;
  assign w_launch   = (r_state == S_IDLE) && start && !abort;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    if (abort && (r_state != S_IDLE)) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:    if (w_launch) w_state_next = S_ISSUE;
        S_ISSUE:   w_state_next = S_CAPTURE;
        S_CAPTURE: w_state_next = S_HOLD;
        S_HOLD:    if (win_ready) w_state_next = w_last ? S_FIN : S_ISSUE;
        S_FIN:     w_state_next = S_IDLE;
        default:   w_state_next = S_IDLE;
      endcase
    end
  end

  // Scan position and captured window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row      <= '0;
      r_col      <= '0;
      r_row_base <= '0;
      r_win_data <= '0;
    end else begin
      if (w_launch) begin
        r_row      <= '0;
        r_col      <= '0;
        r_row_base <= '0;
      end

      if ((r_state == S_CAPTURE) && !abort) begin
        r_win_data <= rdata;
      end

      // On the final window the position is left in place so win_row/win_col
      // still name the last window after the scan completes.
      if (w_accept) begin
        if (w_col_ok) begin
          r_col <= w_col_step[9:0];
        end else if (w_row_ok) begin
          r_col      <= '0;
          r_row      <= w_row_step[9:0];
          r_row_base <= r_row_base + ROW_PITCH;
        end
      end
    end
  end

  // Outputs are decoded from registered state, so reset clears them at once.
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_FIN);
  assign ren       = (r_state == S_ISSUE);
  assign win_valid = (r_state == S_HOLD);
  assign raddr     = r_row_base + A_WIDTH'(r_col);
  assign win_data  = r_win_data;
  assign win_row   = r_row;
  assign win_col   = r_col;

endmodule

// File: doc/window_fetch_ctrl.md
WINDOW_FETCH_CTRL -- requirements
Module: window_fetch_ctrl

Interface
REQ-001 SHALL have parameter IMG_W, default 640, image row pitch in pixels (one pixel per memory byte).
REQ-002 SHALL have parameter IMG_H, default 480, image height in rows.
REQ-003 SHALL have parameter WIN, default 7, window edge in pixels; fixed at 7 to match the 392-bit window word.
REQ-004 SHALL have parameter STRIDE, default 1, window step in pixels, horizontal and vertical.
REQ-005 SHALL have parameter A_WIDTH, default 19, memory address width.
REQ-006 SHALL have parameter MASKLEN, default 392, window word width (WIN*WIN*8).
REQ-007 SHALL have port clk  input  1  single clock, rising edge.
REQ-008 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-009 SHALL have port start  input  1  begin a full-image scan when idle.
REQ-010 SHALL have port abort  input  1  terminate a scan in progress.
REQ-011 SHALL have port busy  output  1  scan in progress.
REQ-012 SHALL have port done  output  1  one-cycle pulse after the last window is accepted.
REQ-013 SHALL have port ren  output  1  memory read enable.
REQ-014 SHALL have port raddr  output  A_WIDTH  window top-left byte address.
REQ-015 SHALL have port rdata  input  MASKLEN  window word; registered by memory, valid the cycle after ren.
REQ-016 SHALL have port win_valid  output  1  win_data holds an unconsumed window.
REQ-017 SHALL have port win_ready  input  1  downstream accepts the window.
REQ-018 SHALL have port win_data  output  MASKLEN  captured window, row 0 pixel 0 in the MSBs.
REQ-019 SHALL have port win_row  output  10  top row of the current window.
REQ-020 SHALL have port win_col  output  10  left column of the current window.

Function
REQ-021 SHALL implement FSM states IDLE, ISSUE, CAPTURE, HOLD, FIN.
REQ-022 IDLE: when start=1, SHALL clear row/col/row_base to 0, set busy and go to ISSUE; start SHALL be ignored in every other state.
REQ-023 ISSUE: SHALL drive ren=1 for exactly one cycle with raddr=row_base+col, then go to CAPTURE; ren SHALL be 0 in all other states.
REQ-024 CAPTURE: SHALL load win_data<=rdata, set win_valid=1 and go to HOLD.
REQ-025 HOLD: win_valid, win_data, win_row and win_col SHALL be held stable until win_ready=1.
REQ-026 On win_ready=1 in HOLD: SHALL clear win_valid; if col+STRIDE<=IMG_W-WIN, col+=STRIDE; else col=0, row+=STRIDE, row_base+=IMG_W*STRIDE; then ISSUE.
REQ-027 The last window (the next col and row steps both out of range) accepted in HOLD SHALL go to FIN, not ISSUE.
REQ-028 FIN: SHALL pulse done=1 for one cycle, clear busy and return to IDLE.
REQ-029 Minimum throughput SHALL be one window per 3 cycles (ISSUE, CAPTURE, HOLD with win_ready=1).
REQ-030 raddr SHALL be computed incrementally (row_base adder, no multiplier); maximum 303353 at defaults SHALL fit in A_WIDTH.
REQ-031 abort=1 in any non-IDLE state SHALL, at the next edge, force IDLE, clear busy and win_valid and drop ren, without pulsing done; abort has priority over win_ready.
REQ-032 abort in IDLE SHALL have no effect; abort and start together in IDLE SHALL leave the block in IDLE.
REQ-033 win_ready while win_valid=0 SHALL be ignored.

Reset
REQ-034 rst_n=0 SHALL asynchronously force IDLE and set busy=0, done=0, ren=0, raddr=0, win_valid=0, win_data=0, win_row=0, win_col=0.
REQ-035 Reset mid-scan SHALL discard all progress; the next start SHALL scan from row 0, col 0.

Verification
REQ-036 Defaults, memory bytes preloaded with (addr mod 256), start -> first ren at raddr=0; win_data MSB byte=0x00, byte 7=0x80 (addr 640), LSB byte=0x06 (addr 3846).
REQ-037 win_ready tied 1, STRIDE=1 -> exactly 300516 windows (634x474); last raddr=303353, win_row=473, win_col=633; one done pulse.
REQ-038 win_ready held 0 for 10 cycles in HOLD -> win_data/win_row/win_col stable, ren=0 throughout; accept on cycle 11.
REQ-039 abort asserted in CAPTURE on window 5 -> IDLE next cycle, win_valid=0, busy=0, no done; restart begins at raddr=0.
REQ-040 start pulsed during HOLD -> no effect; rst_n low mid-scan -> all outputs zero immediately, regardless of clk.
REQ-041 STRIDE=2 -> 317x237=75129 windows; second raddr=2; first window of row 2 at raddr=1280.
